// File: rtl/id_ex_if.sv
// ID/EX pipeline bundle: the registered decode result handed from the ID stage to EX,
// including the source addresses EX needs for operand forwarding.
interface id_ex_if #(
  parameter int WORD_WIDTH = 32,
  parameter int REG_ADDR_W = 4
);
  logic                  valid_out;
  logic [WORD_WIDTH-1:0] pc;
  logic [WORD_WIDTH-1:0] val_Rn;
  logic [WORD_WIDTH-1:0] val_Rm;
  logic [REG_ADDR_W-1:0] reg_file_dst;
  logic [REG_ADDR_W-1:0] src1_out;
  logic [REG_ADDR_W-1:0] src2_out;
  logic [11:0]           shifter_operand;
  logic [23:0]           signed_immediate;
  logic [3:0]            EX_command;
  logic                  mem_read_out;
  logic                  mem_write_out;
  logic                  WB_en_out;
  logic                  Imm_out;
  logic                  B_out;
  logic                  SR_update_out;

  modport master (
    output valid_out, pc, val_Rn, val_Rm, reg_file_dst, src1_out, src2_out,
           shifter_operand, signed_immediate, EX_command, mem_read_out,
           mem_write_out, WB_en_out, Imm_out, B_out, SR_update_out
  );

  modport slave (
    input  valid_out, pc, val_Rn, val_Rm, reg_file_dst, src1_out, src2_out,
           shifter_operand, signed_immediate, EX_command, mem_read_out,
           mem_write_out, WB_en_out, Imm_out, B_out, SR_update_out
  );
endinterface

// File: rtl/id_stage_hz.sv
// Pipelined ARM-subset decode stage: write-through register file, RAW hazard detection
// against EX/MEM, and an ID/EX register that takes bubbles on flush, stall or empty slot.
module id_stage_hz #(
  parameter int WORD_WIDTH = 32,
  parameter int REG_ADDR_W = 4,
  parameter int FORWARDING = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_in,
  input  logic [WORD_WIDTH-1:0] pc_in,
  input  logic [WORD_WIDTH-1:0] instruction_in,
  input  logic [3:0]            status_register,
  input  logic                  flush,
  input  logic                  wb_en,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  input  logic [WORD_WIDTH-1:0] wb_data,
  input  logic                  ex_wb_en,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_dst,
  input  logic                  mem_wb_en,
  input  logic [REG_ADDR_W-1:0] mem_dst,
  output logic                  hazard,
  id_ex_if.master               id_ex
);

  localparam int NUM_REGS = 2 ** REG_ADDR_W;

  typedef struct packed {
    logic [3:0] cmd;
    logic       mem_read;
    logic       mem_write;
    logic       wb;
    logic       b;
    logic       sr_update;
  } ctrl_t;

  logic [3:0]            cond;
  logic [1:0]            mode;
  logic                  imm;
  logic [3:0]            opcode;
  logic                  s_bit;
  logic [REG_ADDR_W-1:0] rn, rd, rm;

  assign cond   = instruction_in[31:28];
  assign mode   = instruction_in[27:26];
  assign imm    = instruction_in[25];
  assign opcode = instruction_in[24:21];
  assign s_bit  = instruction_in[20];
  assign rn     = instruction_in[16 +: REG_ADDR_W];
  assign rd     = instruction_in[12 +: REG_ADDR_W];
  assign rm     = instruction_in[0 +: REG_ADDR_W];

  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] sr);
    logic n, z, cy, v;
    {n, z, cy, v} = sr;
    case (c)
      4'b0000: cond_pass = z;
      4'b0001: cond_pass = !z;
      4'b0010: cond_pass = cy;
      4'b0011: cond_pass = !cy;
      4'b0100: cond_pass = n;
      4'b0101: cond_pass = !n;
      4'b0110: cond_pass = v;
      4'b0111: cond_pass = !v;
      4'b1000: cond_pass = cy && !z;
      4'b1001: cond_pass = !cy || z;
      4'b1010: cond_pass = (n == v);
      4'b1011: cond_pass = (n != v);
      4'b1100: cond_pass = !z && (n == v);
      4'b1101: cond_pass = z || (n != v);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  endfunction

  ctrl_t                 ctrl;
  logic                  use_src1, use_src2;
  logic [REG_ADDR_W-1:0] src2_addr;

  // NOTE: every signal assigned in this block gets a default first, so no path can infer a latch.
  always_comb begin
    ctrl     = '0;
    use_src1 = 1'b1;
    use_src2 = 1'b0;
    case (mode)
      2'b00: begin
        use_src2 = !imm;
        case (opcode)
          4'b1101: begin ctrl.cmd = 4'b0001; ctrl.wb = 1'b1; ctrl.sr_update = s_bit; use_src1 = 1'b0; end
          4'b1111: begin ctrl.cmd = 4'b1001; ctrl.wb = 1'b1; ctrl.sr_update = s_bit; use_src1 = 1'b0; end
          4'b0100: begin ctrl.cmd = 4'b0010; ctrl.wb = 1'b1; ctrl.sr_update = s_bit; end
          4'b0101: begin ctrl.cmd = 4'b0011; ctrl.wb = 1'b1; ctrl.sr_update = s_bit; end
          4'b0010: begin ctrl.cmd = 4'b0100; ctrl.wb = 1'b1; ctrl.sr_update = s_bit; end
          4'b0110: begin ctrl.cmd = 4'b0101; ctrl.wb = 1'b1; ctrl.sr_update = s_bit; end
          4'b0000: begin ctrl.cmd = 4'b0110; ctrl.wb = 1'b1; ctrl.sr_update = s_bit; end
          4'b1100: begin ctrl.cmd = 4'b0111; ctrl.wb = 1'b1; ctrl.sr_update = s_bit; end
          4'b0001: begin ctrl.cmd = 4'b1000; ctrl.wb = 1'b1; ctrl.sr_update = s_bit; end
          4'b1010: begin ctrl.cmd = 4'b0100; ctrl.sr_update = 1'b1; end
          4'b1000: begin ctrl.cmd = 4'b0110; ctrl.sr_update = 1'b1; end
          default: ;
        endcase
      end
      2'b01: begin
        ctrl.cmd       = 4'b0010;
        ctrl.mem_read  = s_bit;
        ctrl.mem_write = !s_bit;
        ctrl.wb        = s_bit;
        use_src2       = !s_bit;
      end
      2'b10: begin
        ctrl.b   = 1'b1;
        use_src1 = 1'b0;
      end
      default: ;
    endcase
    // Source usage stays independent of the condition; only the controls are squashed.
    if (!cond_pass(cond, status_register)) ctrl = '0;
  end

  // STR reads Rd as its store data, so the second read port follows Rd for it.
  assign src2_addr = (mode == 2'b01 && !s_bit) ? rd : rm;

  logic raw;
  always_comb begin
    raw = 1'b0;
    if (FORWARDING == 0) begin
      raw = (use_src1 && ((ex_wb_en && rn == ex_dst) || (mem_wb_en && rn == mem_dst))) ||
            (use_src2 && ((ex_wb_en && src2_addr == ex_dst) || (mem_wb_en && src2_addr == mem_dst)));
    end else begin
      raw = ex_wb_en && ex_mem_read &&
            ((use_src1 && rn == ex_dst) || (use_src2 && src2_addr == ex_dst));
    end
  end

  assign hazard = valid_in && !flush && raw;

  logic [WORD_WIDTH-1:0] regs [NUM_REGS];

  // NOTE: this array is cleared on reset, so it maps to flops rather than a RAM macro.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wb_en) begin
      regs[wb_addr] <= wb_data;
    end
  end

  logic [WORD_WIDTH-1:0] rd_val1, rd_val2;
  assign rd_val1 = (wb_en && wb_addr == rn)        ? wb_data : regs[rn];
  assign rd_val2 = (wb_en && wb_addr == src2_addr) ? wb_data : regs[src2_addr];

  logic bubble;
  assign bubble = flush || hazard || !valid_in;

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_ex.valid_out        <= 1'b0;
      id_ex.pc               <= '0;
      id_ex.val_Rn           <= '0;
      id_ex.val_Rm           <= '0;
      id_ex.reg_file_dst     <= '0;
      id_ex.src1_out         <= '0;
      id_ex.src2_out         <= '0;
      id_ex.shifter_operand  <= '0;
      id_ex.signed_immediate <= '0;
      id_ex.Imm_out          <= 1'b0;
      id_ex.EX_command       <= '0;
      id_ex.mem_read_out     <= 1'b0;
      id_ex.mem_write_out    <= 1'b0;
      id_ex.WB_en_out        <= 1'b0;
      id_ex.B_out            <= 1'b0;
      id_ex.SR_update_out    <= 1'b0;
    end else begin
      id_ex.pc               <= pc_in;
      id_ex.val_Rn           <= rd_val1;
      id_ex.val_Rm           <= rd_val2;
      id_ex.reg_file_dst     <= rd;
      id_ex.src1_out         <= rn;
      id_ex.src2_out         <= src2_addr;
      id_ex.shifter_operand  <= instruction_in[11:0];
      id_ex.signed_immediate <= instruction_in[23:0];
      id_ex.Imm_out          <= imm;
      if (bubble) begin
        id_ex.valid_out     <= 1'b0;
        id_ex.EX_command    <= '0;
        id_ex.mem_read_out  <= 1'b0;
        id_ex.mem_write_out <= 1'b0;
        id_ex.WB_en_out     <= 1'b0;
        id_ex.B_out         <= 1'b0;
        id_ex.SR_update_out <= 1'b0;
      end else begin
        id_ex.valid_out     <= 1'b1;
        id_ex.EX_command    <= ctrl.cmd;
        id_ex.mem_read_out  <= ctrl.mem_read;
        id_ex.mem_write_out <= ctrl.mem_write;
        id_ex.WB_en_out     <= ctrl.wb;
        id_ex.B_out         <= ctrl.b;
        id_ex.SR_update_out <= ctrl.sr_update;
      end
    end
  end

endmodule

// File: tb/tb_id_stage_hz.sv
// Directed bench for id_stage_hz: two instances (stall-always and load-use-only) share
// the same stimulus; expected values are hand-derived per scenario.
module tb_id_stage_hz;
  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic [31:0] pc_in, instruction_in;
  logic [3:0]  status_register;
  logic        flush;
  logic        wb_en;
  logic [3:0]  wb_addr;
  logic [31:0] wb_data;
  logic        ex_wb_en, ex_mem_read, mem_wb_en;
  logic [3:0]  ex_dst, mem_dst;
  logic        hazard0, hazard1;

  int passed = 0;
  int total  = 0;

  id_ex_if #(.WORD_WIDTH(32), .REG_ADDR_W(4)) ex0 ();
  id_ex_if #(.WORD_WIDTH(32), .REG_ADDR_W(4)) ex1 ();

  id_stage_hz #(.WORD_WIDTH(32), .REG_ADDR_W(4), .FORWARDING(0)) dut0 (
    .clk(clk), .rst(rst), .valid_in(valid_in), .pc_in(pc_in), .instruction_in(instruction_in),
    .status_register(status_register), .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .ex_wb_en(ex_wb_en), .ex_mem_read(ex_mem_read), .ex_dst(ex_dst),
    .mem_wb_en(mem_wb_en), .mem_dst(mem_dst), .hazard(hazard0), .id_ex(ex0)
  );

  id_stage_hz #(.WORD_WIDTH(32), .REG_ADDR_W(4), .FORWARDING(1)) dut1 (
    .clk(clk), .rst(rst), .valid_in(valid_in), .pc_in(pc_in), .instruction_in(instruction_in),
    .status_register(status_register), .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .ex_wb_en(ex_wb_en), .ex_mem_read(ex_mem_read), .ex_dst(ex_dst),
    .mem_wb_en(mem_wb_en), .mem_dst(mem_dst), .hazard(hazard1), .id_ex(ex1)
  );

  always #5 clk = ~clk;

  localparam logic [3:0] AL = 4'b1110;

  function automatic logic [31:0] enc(input logic [3:0] cond, input logic [1:0] mode,
                                      input logic imm, input logic [3:0] opc, input logic s,
                                      input logic [3:0] rn, input logic [3:0] rd,
                                      input logic [11:0] op2);
    return {cond, mode, imm, opc, s, rn, rd, op2};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    valid_in = 1'b0; pc_in = '0; instruction_in = '0; status_register = '0; flush = 1'b0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    ex_wb_en = 1'b0; ex_mem_read = 1'b0; ex_dst = '0; mem_wb_en = 1'b0; mem_dst = '0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    valid_in = 1'b0; pc_in = 32'hFFFF_FFF0; instruction_in = 32'hDEAD_BEEF;
    status_register = 4'hF; flush = 1'b0; wb_en = 1'b1; wb_addr = 4'd5; wb_data = 32'h1234;
    ex_wb_en = 1'b1; ex_mem_read = 1'b1; ex_dst = 4'hE; mem_wb_en = 1'b1; mem_dst = 4'hE;
    #2;
    total++; if (hazard0 !== 1'b0) $display("FAIL rst_hazard0: got %0b want 0", hazard0); else passed++;
    total++; if (hazard1 !== 1'b0) $display("FAIL rst_hazard1: got %0b want 0", hazard1); else passed++;
    total++; if ({ex0.valid_out, ex0.EX_command, ex0.WB_en_out, ex0.B_out} !== 7'b0)
      $display("FAIL rst_ctrl0: got %b want 0", {ex0.valid_out, ex0.EX_command, ex0.WB_en_out, ex0.B_out}); else passed++;
    valid_in = 1'b1;
    tick(); tick();
    total++; if (ex0.valid_out !== 1'b0) $display("FAIL rst_hold_valid: got %0b want 0", ex0.valid_out); else passed++;
    total++; if (ex0.pc !== 32'h0) $display("FAIL rst_hold_pc: got %h want 0", ex0.pc); else passed++;
    total++; if (ex1.val_Rn !== 32'h0) $display("FAIL rst_hold_valrn: got %h want 0", ex1.val_Rn); else passed++;
    set_idle();
    rst = 1'b1;
    for (int i = 0; i < 16; i++) begin
      valid_in = 1'b1;
      instruction_in = enc(AL, 2'b00, 1'b0, 4'b1101, 1'b0, i[3:0], 4'd1, {8'h00, i[3:0]});
      tick();
      total++; if ({ex0.valid_out, ex0.val_Rn, ex0.val_Rm} !== {1'b1, 64'h0})
        $display("FAIL rst_read_r%0d: got v=%0b rn=%h rm=%h want v=1 rn=0 rm=0", i, ex0.valid_out, ex0.val_Rn, ex0.val_Rm);
      else passed++;
    end
  endtask

  task automatic test_write_through();
    set_idle();
    valid_in = 1'b1; pc_in = 32'h40;
    instruction_in = enc(AL, 2'b00, 1'b0, 4'b0100, 1'b0, 4'd2, 4'd1, 12'h003);
    wb_en = 1'b1; wb_addr = 4'd2; wb_data = 32'd5;
    tick();
    total++; if (ex0.valid_out !== 1'b1) $display("FAIL wt_valid: got %0b want 1", ex0.valid_out); else passed++;
    total++; if (ex0.EX_command !== 4'b0010) $display("FAIL wt_cmd: got %b want 0010", ex0.EX_command); else passed++;
    total++; if (ex0.WB_en_out !== 1'b1) $display("FAIL wt_wb: got %0b want 1", ex0.WB_en_out); else passed++;
    total++; if (ex0.val_Rn !== 32'd5) $display("FAIL wt_valrn: got %h want 5", ex0.val_Rn); else passed++;
    total++; if ({ex0.reg_file_dst, ex0.src1_out, ex0.src2_out} !== {4'd1, 4'd2, 4'd3})
      $display("FAIL wt_addrs: got %h want 123", {ex0.reg_file_dst, ex0.src1_out, ex0.src2_out}); else passed++;
    total++; if (ex0.pc !== 32'h40) $display("FAIL wt_pc: got %h want 40", ex0.pc); else passed++;
    instruction_in = enc(AL, 2'b00, 1'b0, 4'b0100, 1'b0, 4'd2, 4'd1, 12'h00F);
    wb_addr = 4'd15; wb_data = 32'hDEAD_BEEF;
    tick();
    total++; if (ex0.val_Rn !== 32'd5) $display("FAIL wt_stored_r2: got %h want 5", ex0.val_Rn); else passed++;
    total++; if (ex0.val_Rm !== 32'hDEAD_BEEF) $display("FAIL wt_r15_bypass: got %h want deadbeef", ex0.val_Rm); else passed++;
    wb_en = 1'b0;
    tick();
    total++; if (ex0.val_Rm !== 32'hDEAD_BEEF) $display("FAIL wt_r15_stored: got %h want deadbeef", ex0.val_Rm); else passed++;
  endtask

  task automatic test_stall_f0();
    set_idle();
    valid_in = 1'b1; pc_in = 32'd100;
    instruction_in = enc(AL, 2'b00, 1'b0, 4'b0100, 1'b0, 4'd2, 4'd1, 12'h003);
    ex_wb_en = 1'b1; ex_dst = 4'd3;
    #1;
    total++; if (hazard0 !== 1'b1) $display("FAIL f0_ex_hazard: got %0b want 1", hazard0); else passed++;
    total++; if (hazard1 !== 1'b0) $display("FAIL f1_ex_nohazard: got %0b want 0", hazard1); else passed++;
    tick();
    total++; if (ex0.valid_out !== 1'b0) $display("FAIL f0_bubble1: got %0b want 0", ex0.valid_out); else passed++;
    total++; if (ex1.valid_out !== 1'b1) $display("FAIL f1_issue: got %0b want 1", ex1.valid_out); else passed++;
    ex_wb_en = 1'b0; mem_wb_en = 1'b1; mem_dst = 4'd3;
    #1;
    total++; if (hazard0 !== 1'b1) $display("FAIL f0_mem_hazard: got %0b want 1", hazard0); else passed++;
    tick();
    total++; if (ex0.valid_out !== 1'b0) $display("FAIL f0_bubble2: got %0b want 0", ex0.valid_out); else passed++;
    mem_wb_en = 1'b0;
    #1;
    total++; if (hazard0 !== 1'b0) $display("FAIL f0_clear: got %0b want 0", hazard0); else passed++;
    tick();
    total++; if ({ex0.valid_out, ex0.EX_command, ex0.pc} !== {1'b1, 4'b0010, 32'd100})
      $display("FAIL f0_reissue: got v=%0b cmd=%b pc=%0d want v=1 cmd=0010 pc=100", ex0.valid_out, ex0.EX_command, ex0.pc); else passed++;
    valid_in = 1'b0;
    tick();
    total++; if (ex0.valid_out !== 1'b0) $display("FAIL f0_no_dup: got %0b want 0", ex0.valid_out); else passed++;
    valid_in = 1'b1;
    instruction_in = enc(AL, 2'b00, 1'b1, 4'b1101, 1'b0, 4'd2, 4'd1, 12'h0FF);
    ex_wb_en = 1'b1; ex_dst = 4'd2; mem_wb_en = 1'b1; mem_dst = 4'd2;
    #1;
    total++; if (hazard0 !== 1'b0) $display("FAIL unused_src: got %0b want 0", hazard0); else passed++;
    tick();
    total++; if ({ex0.valid_out, ex0.EX_command} !== {1'b1, 4'b0001})
      $display("FAIL mov_imm_issue: got %b want 10001", {ex0.valid_out, ex0.EX_command}); else passed++;
  endtask

  task automatic test_load_use_f1();
    set_idle();
    valid_in = 1'b1; pc_in = 32'd200;
    instruction_in = enc(AL, 2'b00, 1'b0, 4'b0010, 1'b0, 4'd4, 4'd5, 12'h006);
    ex_wb_en = 1'b1; ex_mem_read = 1'b1; ex_dst = 4'd4;
    #1;
    total++; if (hazard1 !== 1'b1) $display("FAIL lu_hazard: got %0b want 1", hazard1); else passed++;
    tick();
    total++; if (ex1.valid_out !== 1'b0) $display("FAIL lu_bubble: got %0b want 0", ex1.valid_out); else passed++;
    ex_wb_en = 1'b0; ex_mem_read = 1'b0; mem_wb_en = 1'b1; mem_dst = 4'd4;
    #1;
    total++; if (hazard1 !== 1'b0) $display("FAIL lu_mem_nohazard: got %0b want 0", hazard1); else passed++;
    total++; if (hazard0 !== 1'b1) $display("FAIL lu_f0_mem_hazard: got %0b want 1", hazard0); else passed++;
    tick();
    total++; if ({ex1.valid_out, ex1.EX_command, ex1.pc} !== {1'b1, 4'b0100, 32'd200})
      $display("FAIL lu_issue: got v=%0b cmd=%b pc=%0d want v=1 cmd=0100 pc=200", ex1.valid_out, ex1.EX_command, ex1.pc); else passed++;
    mem_wb_en = 1'b0; ex_wb_en = 1'b1; ex_mem_read = 1'b0; ex_dst = 4'd6;
    #1;
    total++; if (hazard1 !== 1'b0) $display("FAIL lu_no_load: got %0b want 0", hazard1); else passed++;
    ex_mem_read = 1'b1;
    #1;
    total++; if (hazard1 !== 1'b1) $display("FAIL lu_src2: got %0b want 1", hazard1); else passed++;
  endtask

  task automatic test_cond_str();
    set_idle();
    valid_in = 1'b1; pc_in = 32'd300; status_register = 4'b0000;
    instruction_in = enc(4'b0000, 2'b01, 1'b0, 4'b0100, 1'b0, 4'd2, 4'd15, 12'h010);
    tick();
    total++; if ({ex0.valid_out, ex0.EX_command, ex0.mem_write_out, ex0.WB_en_out} !== 7'b1_0000_0_0)
      $display("FAIL str_eq_fail: got %b want 1000000", {ex0.valid_out, ex0.EX_command, ex0.mem_write_out, ex0.WB_en_out}); else passed++;
    status_register = 4'b0100;
    tick();
    total++; if ({ex0.mem_write_out, ex0.WB_en_out, ex0.mem_read_out, ex0.EX_command} !== 7'b1_0_0_0010)
      $display("FAIL str_eq_pass: got %b want 1000010", {ex0.mem_write_out, ex0.WB_en_out, ex0.mem_read_out, ex0.EX_command}); else passed++;
    total++; if (ex0.src2_out !== 4'd15) $display("FAIL str_src2: got %0d want 15", ex0.src2_out); else passed++;
    total++; if (ex0.val_Rm !== 32'hDEAD_BEEF) $display("FAIL str_data: got %h want deadbeef", ex0.val_Rm); else passed++;
    ex_wb_en = 1'b1; ex_dst = 4'd15;
    #1;
    total++; if (hazard0 !== 1'b1) $display("FAIL str_rd_hazard: got %0b want 1", hazard0); else passed++;
  endtask

  task automatic test_decode();
    logic [31:0] ins [16];
    logic [9:0]  exp [16];
    set_idle();
    status_register = 4'b1000;
    // expected = {valid, cmd[3:0], mem_read, mem_write, wb, b, sr}
    ins[0]  = enc(AL, 2'b00, 1'b1, 4'b1101, 1'b1, 4'd1, 4'd2, 12'h003); exp[0]  = 10'b1_0001_0_0_1_0_1;
    ins[1]  = enc(AL, 2'b00, 1'b1, 4'b1111, 1'b0, 4'd1, 4'd2, 12'h003); exp[1]  = 10'b1_1001_0_0_1_0_0;
    ins[2]  = enc(AL, 2'b00, 1'b0, 4'b0101, 1'b1, 4'd1, 4'd2, 12'h003); exp[2]  = 10'b1_0011_0_0_1_0_1;
    ins[3]  = enc(AL, 2'b00, 1'b0, 4'b0110, 1'b0, 4'd1, 4'd2, 12'h003); exp[3]  = 10'b1_0101_0_0_1_0_0;
    ins[4]  = enc(AL, 2'b00, 1'b0, 4'b0000, 1'b0, 4'd1, 4'd2, 12'h003); exp[4]  = 10'b1_0110_0_0_1_0_0;
    ins[5]  = enc(AL, 2'b00, 1'b0, 4'b1100, 1'b0, 4'd1, 4'd2, 12'h003); exp[5]  = 10'b1_0111_0_0_1_0_0;
    ins[6]  = enc(AL, 2'b00, 1'b0, 4'b0001, 1'b0, 4'd1, 4'd2, 12'h003); exp[6]  = 10'b1_1000_0_0_1_0_0;
    ins[7]  = enc(AL, 2'b00, 1'b0, 4'b1010, 1'b1, 4'd1, 4'd2, 12'h003); exp[7]  = 10'b1_0100_0_0_0_0_1;
    ins[8]  = enc(AL, 2'b00, 1'b0, 4'b1000, 1'b1, 4'd1, 4'd2, 12'h003); exp[8]  = 10'b1_0110_0_0_0_0_1;
    ins[9]  = enc(AL, 2'b00, 1'b0, 4'b0011, 1'b1, 4'd1, 4'd2, 12'h003); exp[9]  = 10'b1_0000_0_0_0_0_0;
    ins[10] = enc(AL, 2'b01, 1'b0, 4'b0100, 1'b1, 4'd1, 4'd2, 12'h004); exp[10] = 10'b1_0010_1_0_1_0_0;
    ins[11] = enc(AL, 2'b10, 1'b1, 4'b0000, 1'b0, 4'd1, 4'd2, 12'h003); exp[11] = 10'b1_0000_0_0_0_1_0;
    ins[12] = enc(AL, 2'b11, 1'b0, 4'b0100, 1'b1, 4'd1, 4'd2, 12'h003); exp[12] = 10'b1_0000_0_0_0_0_0;
    ins[13] = enc(4'b1111, 2'b00, 1'b0, 4'b0100, 1'b0, 4'd1, 4'd2, 12'h003); exp[13] = 10'b1_0000_0_0_0_0_0;
    ins[14] = enc(4'b1011, 2'b00, 1'b0, 4'b0100, 1'b0, 4'd1, 4'd2, 12'h003); exp[14] = 10'b1_0010_0_0_1_0_0;
    ins[15] = enc(4'b1010, 2'b00, 1'b0, 4'b0100, 1'b0, 4'd1, 4'd2, 12'h003); exp[15] = 10'b1_0000_0_0_0_0_0;
    for (int i = 0; i < 16; i++) begin
      valid_in = 1'b1;
      instruction_in = ins[i];
      tick();
      total++;
      if ({ex0.valid_out, ex0.EX_command, ex0.mem_read_out, ex0.mem_write_out, ex0.WB_en_out,
           ex0.B_out, ex0.SR_update_out} !== exp[i])
        $display("FAIL decode_%0d: got %b want %b", i, {ex0.valid_out, ex0.EX_command, ex0.mem_read_out,
                 ex0.mem_write_out, ex0.WB_en_out, ex0.B_out, ex0.SR_update_out}, exp[i]);
      else passed++;
    end
  endtask

  task automatic test_flush();
    set_idle();
    valid_in = 1'b1; flush = 1'b1;
    instruction_in = enc(AL, 2'b00, 1'b0, 4'b0100, 1'b0, 4'd2, 4'd1, 12'h003);
    ex_wb_en = 1'b1; ex_mem_read = 1'b1; ex_dst = 4'd3;
    #1;
    total++; if ({hazard0, hazard1} !== 2'b00) $display("FAIL flush_hazard: got %b want 00", {hazard0, hazard1}); else passed++;
    tick();
    total++; if ({ex0.valid_out, ex1.valid_out, ex0.EX_command, ex0.WB_en_out} !== 7'b0)
      $display("FAIL flush_bubble: got %b want 0", {ex0.valid_out, ex1.valid_out, ex0.EX_command, ex0.WB_en_out}); else passed++;
  endtask

  task automatic test_reset_mid();
    set_idle();
    valid_in = 1'b1; pc_in = 32'd400;
    instruction_in = enc(AL, 2'b00, 1'b0, 4'b0100, 1'b0, 4'd2, 4'd1, 12'h003);
    tick();
    total++; if (ex1.valid_out !== 1'b1) $display("FAIL mid_pre_valid: got %0b want 1", ex1.valid_out); else passed++;
    ex_wb_en = 1'b1; ex_dst = 4'd3;
    tick();
    total++; if (ex0.valid_out !== 1'b0) $display("FAIL mid_stall: got %0b want 0", ex0.valid_out); else passed++;
    rst = 1'b0;
    #1;
    total++; if ({ex1.valid_out, ex1.WB_en_out, ex1.EX_command, ex1.pc} !== 38'h0)
      $display("FAIL mid_rst_clear: got v=%0b wb=%0b cmd=%b pc=%h want 0", ex1.valid_out, ex1.WB_en_out, ex1.EX_command, ex1.pc); else passed++;
    tick();
    rst = 1'b1; ex_wb_en = 1'b0;
    tick();
    total++; if ({ex0.valid_out, ex0.pc, ex0.EX_command} !== {1'b1, 32'd400, 4'b0010})
      $display("FAIL mid_post_issue: got v=%0b pc=%0d cmd=%b want v=1 pc=400 cmd=0010", ex0.valid_out, ex0.pc, ex0.EX_command); else passed++;
    total++; if (ex0.val_Rn !== 32'h0) $display("FAIL mid_rf_cleared: got %h want 0", ex0.val_Rn); else passed++;
  endtask

  initial begin
    set_idle();
    test_reset();
    test_write_through();
    test_stall_f0();
    test_load_use_f1();
    test_cond_str();
    test_decode();
    test_flush();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/id_stage_hz.md
# id_stage_hz

Parametrised, pipelined successor to the combinational decode stage: decodes one ARM-subset instruction per cycle, reads a write-through register file, detects data hazards against the EX and MEM stages, and captures the decoded bundle in an internal ID/EX pipeline register. It sits between the IF/ID register and EX. It drives `hazard` back to IF to freeze the PC and IF/ID, and inserts bubbles into EX on stall or flush.

## Interface
- `WORD_WIDTH`, 32: datapath and instruction width.
- `REG_ADDR_W`, 4: register address width; the file holds 2^REG_ADDR_W registers.
- `FORWARDING`, 0: 0 stalls on any RAW match in EX or MEM; 1 stalls only on a load-use match in EX.

- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `valid_in`  in  1  IF/ID holds a real instruction.
- `pc_in`, `instruction_in`  in  WORD_WIDTH  from IF/ID.
- `status_register`  in  4  {N,Z,C,V}.
- `flush`  in  1  branch taken in EX; squash this decode.
- `wb_en`, `wb_addr`, `wb_data`  in  1/REG_ADDR_W/WORD_WIDTH  register-file write port.
- `ex_wb_en`, `ex_mem_read`, `ex_dst`  in  1/1/REG_ADDR_W  the instruction currently in EX.
- `mem_wb_en`, `mem_dst`  in  1/REG_ADDR_W  the instruction currently in MEM.
- `hazard`  out  1  combinational stall request to IF and IF/ID.
- `src1_out`, `src2_out`  out  REG_ADDR_W  registered source addresses, for EX forwarding.
- `valid_out`, `pc`, `val_Rn`, `val_Rm`, `reg_file_dst`, `shifter_operand[11:0]`, `signed_immediate[23:0]`, `EX_command[3:0]`, `mem_read_out`, `mem_write_out`, `WB_en_out`, `Imm_out`, `B_out`, `SR_update_out`  out  registered ID/EX bundle.

## Operation
- Fields:
  - cond = [31:28], mode = [27:26], Imm = [25], opcode = [24:21], S = [20].
  - Rn = [19:16], Rd = [15:12], Rm = [3:0].
- Decode for mode 00, giving the EX_command. All write back and update SR=S unless noted.
  - MOV 1101 → 0001; MVN 1111 → 1001.
  - ADD 0100 → 0010; ADC 0101 → 0011.
  - SUB 0010 → 0100; SBC 0110 → 0101.
  - AND 0000 → 0110; ORR 1100 → 0111; EOR 0001 → 1000.
  - CMP 1010 → 0100 with no WB and SR=1; TST 1000 → 0110 with no WB and SR=1.
  - Any other opcode gives all controls 0.
- Decode for mode 01 (EX_command 0010):
  - S=1 is LDR: mem_read, WB.
  - S=0 is STR: mem_write.
- Decode for mode 10: B_out=1, no WB.
- Decode for mode 11: all controls 0.
- Condition check uses standard ARM codes 0000–1101; 1110 is always; 1111 is never. A failed condition zeroes all controls. `valid_out` and the data fields still propagate.
- Source usage:
  - src1 = Rn. It is used unless the instruction is MOV, MVN, or a branch.
  - src2 = Rd for STR, otherwise Rm. It is used for STR, or for mode 00 with Imm=0.
  - Unused sources never raise hazards.
- Hazard (combinational), only when valid_in=1 and flush=0:
  - FORWARDING=0: a used source equals ex_dst with ex_wb_en=1, or equals mem_dst with mem_wb_en=1.
  - FORWARDING=1: a used source equals ex_dst with ex_wb_en=1 and ex_mem_read=1.
- Register file:
  - 2^REG_ADDR_W × WORD_WIDTH, written on the rising edge when wb_en=1.
  - Reads are write-through: if wb_en=1 and wb_addr equals the read address, the read returns wb_data in the same cycle.
  - All registers clear to 0 on reset.
- ID/EX register update each rising edge, in priority order:
  1. flush=1: bubble.
  2. hazard=1: bubble.
  3. valid_in=0: bubble.
  4. Otherwise: load the decoded bundle with valid_out=1.
- A bubble sets valid_out and all control outputs (EX_command, mem_read_out, mem_write_out, WB_en_out, B_out, SR_update_out) to 0. Data fields may hold any value.

## Timing
- Reset (rst=0, asynchronous): every registered output is 0 and every register-file entry is 0. Only `hazard` is combinational; it is 0 while valid_in=0.
- Latency: an instruction presented at edge k appears on the outputs after edge k+1.
- Stall: `hazard` asserts in the same cycle as the match. IF must hold `instruction_in` stable. The instruction reissues once the match clears, and no instruction is lost or duplicated.
- FORWARDING=0 with a dependence on the immediately preceding instruction: 2 bubbles.
- FORWARDING=1 with a load-use dependence: exactly 1 bubble.
- Flush and hazard together: flush wins and hazard is forced to 0.
- A WB write in the same cycle as the matching read yields the new value (write-through).
- Writes to the highest register index (2^REG_ADDR_W − 1) behave like any other; there is no special PC alias.
- Reset asserted mid-stall: outputs clear immediately. After release, the first edge with valid_in=1 loads normally.

## Test plan
- Reset: drive rst=0 with garbage inputs → all outputs 0 and hazard 0. After release, read R0–R15 via MOV → all reads 0.
- ADD R1,R2,R3 (cond AL, Imm=0) with R2=5 written via WB in the same cycle → next cycle: valid_out=1, EX_command=0010, WB_en_out=1, val_Rn=5.
- FORWARDING=0, ex_dst=3 with ex_wb_en=1, then ADD R1,R2,R3 → hazard=1 and a bubble (valid_out=0). Then mem_dst=3 → another bubble. Then clear → instruction issues.
- FORWARDING=1, LDR R4 in EX (ex_mem_read=1), then SUB R5,R4,R6 → exactly one bubble. With the same match but ex_mem_read=0 → no stall.
- EQ-conditioned STR with Z=0 → valid_out=1 and all controls 0. With Z=1 → mem_write_out=1, src2_out=Rd, and no WB.
- flush=1 together with a hazard → hazard=0 and a bubble. Asserting reset mid-stream → all outputs 0 within the same cycle.
